ccff_chain_loader: RTL and testbench

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader_pkg.sv | 20 ++
 rtl/ccff_word_serializer.sv | 43 ++++
 rtl/ccff_chain_loader.sv | 132 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ccff_chain_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader_pkg
// Description : Shared state encoding and default sizes for the ccff loader.
// Revision    : 1.0 - initial release
// ============================================================================
package ccff_chain_loader_pkg;

  localparam int c_chain_len_def = 32;
  localparam int c_word_w_def    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ccff_state_e;

endpackage
`default_nettype wire

// File: rtl/ccff_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ccff_word_serializer
// Description : Holds one bitstream word and presents it LSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_word_serializer
  import ccff_chain_loader_pkg::*;
#(
  parameter int WORD_W = c_word_w_def
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_bit,
  output logic              o_last
);

  localparam int c_idx_w = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0]  r_word;
  logic [c_idx_w-1:0] r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_idx  <= '0;
    end else if (i_shift) begin
      r_word <= r_word >> 1;
      r_idx  <= r_idx + c_idx_w'(1);
    end
  end

  assign o_bit  = r_word[0];
  assign o_last = (r_idx == c_idx_w'(WORD_W - 1));

endmodule
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader
// Description : Streams host bitstream words serially into a ccff chain.
//               Optional tail integrity check: define CCFF_TAIL_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = c_chain_len_def,
  parameter int WORD_W    = c_word_w_def
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              tail_err
);

  localparam int c_cnt_w = $clog2(CHAIN_LEN + 1);

  ccff_state_e        r_state;
  ccff_state_e        w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_start_ok;
  logic               w_accept;
  logic               w_shift;
  logic               w_cnt_full;
  logic               w_bit;
  logic               w_last;

  // abort gates the handshake and the chain clock so it always wins
  assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
  assign w_accept   = (r_state == ST_LOAD) && cfg_valid && !abort;
  assign w_shift    = (r_state == ST_SHIFT) && !abort;
  assign w_cnt_nxt  = r_cnt + c_cnt_w'(1);
  assign w_cnt_full = (w_cnt_nxt == c_cnt_w'(CHAIN_LEN));

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort)          w_state_nxt = ST_IDLE;
        else if (cfg_valid) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort)           w_state_nxt = ST_IDLE;
        else if (w_cnt_full) w_state_nxt = ST_DONE;
        else if (w_last)     w_state_nxt = ST_LOAD;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // leaving SHIFT on reaching CHAIN_LEN keeps the count bounded
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= w_cnt_nxt;
    end
  end

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk     (prog_clk),
    .rst     (prog_reset),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_word  (cfg_data),
    .o_bit   (w_bit),
    .o_last  (w_last)
  );

  assign cfg_ready   = (r_state == ST_LOAD) && !abort;
  assign ccff_clk_en = w_shift;
  assign ccff_head   = w_shift && w_bit;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);

`ifdef CCFF_TAIL_CHECK_EN
  logic r_tail_err;

  // chain flops reset to 0, so a 1 at the tail mid-load means a short chain
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      r_tail_err <= 1'b0;
    end else if (w_start_ok) begin
      r_tail_err <= 1'b0;
    end else if ((r_state == ST_SHIFT) && ccff_tail) begin
      r_tail_err <= 1'b1;
    end
  end

  assign tail_err = r_tail_err;
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
  assign tail_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// Directed bench for ccff_chain_loader: a 32-flop loader driving a 24-flop
// chain model, plus a 12-flop loader.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_start = 0, a_abort = 0, a_valid = 0;
  logic [7:0] a_data = '0;
  logic       a_ready, a_head, a_clk_en, a_tail, a_busy, a_done, a_terr;
  logic       b_start = 0, b_abort = 0, b_valid = 0;
  logic [7:0] b_data = '0;
  logic       b_ready, b_head, b_clk_en, b_busy, b_done, b_terr;

  logic        chain_clr = 1'b0;
  logic [23:0] chain_a;
  always @(posedge clk or posedge rst) begin
    if (rst || chain_clr) chain_a <= '0;
    else if (a_clk_en)    chain_a <= {chain_a[22:0], a_head};
  end
  assign a_tail = chain_a[23];

  ccff_chain_loader #(.CHAIN_LEN(32), .WORD_W(8)) u_a (
    .prog_clk(clk), .prog_reset(rst), .start(a_start), .abort(a_abort),
    .cfg_data(a_data), .cfg_valid(a_valid), .cfg_ready(a_ready),
    .ccff_head(a_head), .ccff_clk_en(a_clk_en), .ccff_tail(a_tail),
    .busy(a_busy), .done(a_done), .tail_err(a_terr));

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_b (
    .prog_clk(clk), .prog_reset(rst), .start(b_start), .abort(b_abort),
    .cfg_data(b_data), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .ccff_head(b_head), .ccff_clk_en(b_clk_en), .ccff_tail(1'b0),
    .busy(b_busy), .done(b_done), .tail_err(b_terr));

`ifdef CCFF_TAIL_CHECK_EN
  localparam int TERR_AT  = 25;
  localparam logic TERR_END = 1'b1;
`else
  localparam int TERR_AT  = -1;
  localparam logic TERR_END = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int n_shift, n_done, n_acc, c_done, c_last, c_end, terr_first;
  logic [31:0] hbits;

  task automatic start_load(input bit sel);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    chain_clr = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; b_start = 1'b0; chain_clr = 1'b0;
  endtask

  // Feeds words from LOAD until the loader returns to IDLE; optional abort.
  task automatic run(input bit sel, input logic [31:0] words, input int abort_at);
    int widx;
    logic rdy, en, hd, dn, by, te;
    widx = 0; n_shift = 0; n_done = 0; hbits = '0;
    c_done = -1; c_last = -1; c_end = -1; terr_first = -1;
    for (int c = 0; c < 120; c++) begin
      if (sel) begin
        b_valid = 1'b1; b_abort = (n_shift == abort_at);
        b_data  = (widx < 4) ? words[widx*8 +: 8] : 8'h00;
      end else begin
        a_valid = 1'b1; a_abort = (n_shift == abort_at);
        a_data  = (widx < 4) ? words[widx*8 +: 8] : 8'h00;
      end
      @(negedge clk);
      rdy = sel ? b_ready  : a_ready;
      en  = sel ? b_clk_en : a_clk_en;
      hd  = sel ? b_head   : a_head;
      dn  = sel ? b_done   : a_done;
      by  = sel ? b_busy   : a_busy;
      te  = sel ? b_terr   : a_terr;
      if (rdy) widx++;
      if (te && terr_first < 0) terr_first = n_shift;
      if (en) begin
        if (n_shift < 32) hbits[n_shift] = hd;
        n_shift++;
        c_last = c;
      end
      if (dn) begin n_done++; c_done = c; end
      if (!by) begin c_end = c; break; end
      @(posedge clk); #1;
    end
    n_acc = widx;
    a_valid = 1'b0; a_abort = 1'b0; b_valid = 1'b0; b_abort = 1'b0;
    if (c_end < 0) begin
      checks++; failures++;
      $error("FAIL run_timeout observed=no_idle expected=idle_within_120");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int nrdy, nen, nbusy;
    // reset state, with start held during reset
    a_start = 1'b1;
    @(negedge clk);
    chk("rst_ready",  a_ready,  0);
    chk("rst_head",   a_head,   0);
    chk("rst_clk_en", a_clk_en, 0);
    chk("rst_busy",   a_busy,   0);
    chk("rst_done",   a_done,   0);
    chk("rst_terr",   a_terr,   0);
    @(posedge clk); #1;
    rst = 1'b0; a_start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", a_busy, 0);
    @(posedge clk); #1;

    // four default-size words
    start_load(0);
    run(0, 32'hFF80_0001, -1);
    chk("w4_shifts", n_shift, 32);
    chk("w4_head",   hbits,   32'hFF80_0001);
    chk("w4_done_n", n_done,  1);
    chk("w4_done_c", c_done,  36);
    chk("w4_last_c", c_last,  35);
    chk("w4_idle_c", c_end,   37);
    chk("w4_accept", n_acc,   4);
    chk("w4_terr_at",  terr_first, TERR_AT);
    chk("w4_terr_end", a_terr,     TERR_END);

    // start together with abort in IDLE
    a_start = 1'b1; a_abort = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", a_busy, 0);
    @(posedge clk); #1;

    // LOAD with cfg_valid low for 5 cycles; repeated start ignored
    start_load(0);
    nrdy = 0; nen = 0; nbusy = 0;
    for (int i = 0; i < 5; i++) begin
      a_start = (i == 0); a_valid = 1'b0;
      @(negedge clk);
      nrdy += int'(a_ready); nen += int'(a_clk_en); nbusy += int'(a_busy);
      @(posedge clk); #1;
      a_start = 1'b0;
    end
    chk("stall_ready", nrdy,  5);
    chk("stall_shift", nen,   0);
    chk("stall_busy",  nbusy, 5);

    // abort after 10 shifts
    run(0, 32'h0000_0000, 10);
    chk("abort_shifts", n_shift, 10);
    chk("abort_done",   n_done,  0);
    chk("abort_idle_c", c_end,   13);

    // restart after abort: full count from zero
    start_load(0);
    run(0, 32'hFFFF_FFFF, -1);
    chk("re_shifts", n_shift, 32);
    chk("re_head",   hbits,   32'hFFFF_FFFF);
    chk("re_done_n", n_done,  1);
    chk("re_done_c", c_done,  36);
    chk("re_terr_at", terr_first, TERR_AT);

    // CHAIN_LEN=12: second word cut after four bits
    start_load(1);
    run(1, 32'h0000_CDAB, -1);
    chk("c12_shifts", n_shift, 12);
    chk("c12_head",   hbits,   32'h0000_0DAB);
    chk("c12_done_n", n_done,  1);
    chk("c12_done_c", c_done,  14);
    chk("c12_last_c", c_last,  13);
    chk("c12_accept", n_acc,   2);
    chk("c12_terr",   b_terr,  0);

    // reset mid-load
    start_load(0);
    a_valid = 1'b1; a_data = 8'hFF;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("midrst_busy",   a_busy,   0);
    chk("midrst_clk_en", a_clk_en, 0);
    chk("midrst_ready",  a_ready,  0);
    @(posedge clk); #1;
    rst = 1'b0; a_valid = 1'b0;
    n_done = 0;
    repeat (4) begin
      @(negedge clk);
      n_done += int'(a_done);
    end
    chk("midrst_no_done", n_done, 0);
    chk("midrst_idle",    a_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
